// File: rtl/nand_cpu_pkg.sv
// Shared types for the NAND CPU core: machine sizes, the issue-queue request
// and the modular ROB age helper.
package nand_cpu_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int NUM_D_REG = 32;
  localparam int NUM_S_REG = 8;

  localparam int ROB_W    = $clog2(ROB_SIZE);
  localparam int DR_W     = $clog2(NUM_D_REG);
  localparam int SR_W     = $clog2(NUM_S_REG);
  localparam int ALU_OP_W = 4;
  localparam int IMM_W    = 16;

  typedef struct packed {
    logic [ROB_W-1:0]    rob_addr;
    logic [ALU_OP_W-1:0] alu_op;
    logic [IMM_W-1:0]    immdt;
    logic                use_ra;
    logic [DR_W-1:0]     ra_addr;
    logic                use_rt;
    logic [DR_W-1:0]     rt_addr;
    logic                write_dst;
    logic [DR_W-1:0]     rw_addr;
    logic [SR_W-1:0]     rs_addr;
  } iq_req_t;

  // ROB_SIZE is a power of two, so truncating the difference is the modulo.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] addr,
                                               input logic [ROB_W-1:0] head);
    return addr - head;
  endfunction

endpackage

// File: rtl/iq_oldest_select.sv
// Picks the single oldest eligible entry; ties on age resolve to the lower index.
module iq_oldest_select #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4
) (
  input  logic [DEPTH-1:0]            eligible,
  input  logic [DEPTH-1:0][ROB_W-1:0] age,
  output logic [DEPTH-1:0]            grant
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = eligible[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && eligible[j]) begin
          if ((age[j] < age[i]) || ((age[j] == age[i]) && (j < i))) begin
            grant[i] = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order ALU issue queue: holds renamed ops, wakes their operands, and
// issues up to ISSUE_W per cycle oldest-first by modular ROB age.
module issue_queue
  import nand_cpu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 2,
  parameter int WAKE_W  = 2
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [ROB_W-1:0]               rob_head,
  input  logic                           cp_restore,
  input  logic [ROB_W-1:0]               cp_tail,
  input  logic [NUM_D_REG-1:0]           calc_list,
  input  logic [WAKE_W-1:0]              wake_valid,
  input  logic [WAKE_W-1:0][DR_W-1:0]    wake_addr,
  input  logic                           enq_valid,
  output logic                           enq_ready,
  input  iq_req_t                        enq_entry,
  output logic [ISSUE_W-1:0]             iss_valid,
  input  logic [ISSUE_W-1:0]             iss_ready,
  output iq_req_t [ISSUE_W-1:0]          iss_entry,
  output logic                           full,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  iq_req_t [DEPTH-1:0]            slot_q;
  logic [DEPTH-1:0]               valid_q;
  logic [DEPTH-1:0]               ra_rdy_q;
  logic [DEPTH-1:0]               rt_rdy_q;

  logic [DEPTH-1:0]               ra_eff;
  logic [DEPTH-1:0]               rt_eff;
  logic [DEPTH-1:0]               flush_kill;
  logic [DEPTH-1:0]               eligible;
  logic [DEPTH-1:0]               issued;
  logic [DEPTH-1:0]               valid_d;
  logic [DEPTH-1:0][ROB_W-1:0]    age;
  logic [ROB_W-1:0]               keep_span;
  logic [ISSUE_W-1:0][DEPTH-1:0]  port_take;
  logic [IDX_W-1:0]               free_idx;
  logic [CNT_W-1:0]               count_d;
  logic                           enq_fire;
  logic                           enq_ra_ok;
  logic                           enq_rt_ok;

  function automatic logic src_hit(input logic [DR_W-1:0]              addr,
                                   input logic [NUM_D_REG-1:0]         calc,
                                   input logic [WAKE_W-1:0]            wv,
                                   input logic [WAKE_W-1:0][DR_W-1:0]  wa);
    logic hit;
    hit = calc[addr];
    for (int j = 0; j < WAKE_W; j++) begin
      hit = hit | (wv[j] & (wa[j] == addr));
    end
    return hit;
  endfunction

  assign enq_ready = ~full & ~cp_restore;
  assign enq_fire  = enq_valid & enq_ready;

  // Effective readiness includes this cycle's broadcasts so a woken op can
  // issue in the same cycle its producer writes back.
  always_comb begin
    keep_span = rob_age(cp_tail, rob_head);
    for (int i = 0; i < DEPTH; i++) begin
      age[i]        = rob_age(slot_q[i].rob_addr, rob_head);
      ra_eff[i]     = ra_rdy_q[i] | ~slot_q[i].use_ra |
                      src_hit(slot_q[i].ra_addr, calc_list, wake_valid, wake_addr);
      rt_eff[i]     = rt_rdy_q[i] | ~slot_q[i].use_rt |
                      src_hit(slot_q[i].rt_addr, calc_list, wake_valid, wake_addr);
      flush_kill[i] = cp_restore & valid_q[i] & (age[i] >= keep_span);
      eligible[i]   = valid_q[i] & ra_eff[i] & rt_eff[i] & ~flush_kill[i];
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_port
    logic [DEPTH-1:0] avail;
    logic [DEPTH-1:0] grant;
    iq_req_t          pick;

    if (k == 0) begin : g_first
      assign avail = eligible;
    end else begin : g_next
      assign avail = g_port[k-1].avail & ~g_port[k-1].grant;
    end

    iq_oldest_select #(
      .DEPTH (DEPTH),
      .ROB_W (ROB_W)
    ) u_select (
      .eligible (avail),
      .age      (age),
      .grant    (grant)
    );

    always_comb begin
      pick = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (grant[i]) begin
          pick = pick | slot_q[i];
        end
      end
    end

    assign iss_valid[k] = |grant;
    assign iss_entry[k] = pick;
    assign port_take[k] = grant & {DEPTH{iss_ready[k]}};
  end

  always_comb begin
    issued = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      issued = issued | port_take[k];
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    enq_ra_ok = ~enq_entry.use_ra |
                src_hit(enq_entry.ra_addr, calc_list, wake_valid, wake_addr);
    enq_rt_ok = ~enq_entry.use_rt |
                src_hit(enq_entry.rt_addr, calc_list, wake_valid, wake_addr);
  end

  always_comb begin
    valid_d = valid_q & ~issued & ~flush_kill;
    if (enq_fire) begin
      valid_d[free_idx] = 1'b1;
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q  <= '0;
      ra_rdy_q <= '0;
      rt_rdy_q <= '0;
      count    <= '0;
      full     <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      count    <= count_d;
      full     <= (count_d == FULL_CNT);
      ra_rdy_q <= ra_eff;
      rt_rdy_q <= rt_eff;
      if (enq_fire) begin
        ra_rdy_q[free_idx] <= enq_ra_ok;
        rt_rdy_q[free_idx] <= enq_rt_ok;
      end
    end
  end

  // Payload needs no reset: it is only observed through valid_q.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      slot_q[free_idx] <= enq_entry;
    end
  end

  dropped_enq_c : cover property (@(posedge clk) disable iff (!n_rst)
                                  enq_valid && !enq_ready);

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with a queue-based reference model checked every cycle.
module tb_issue_queue;
  import nand_cpu_pkg::*;

  localparam int DEPTH   = 8;
  localparam int ISSUE_W = 2;
  localparam int WAKE_W  = 2;

  logic                         clk = 1'b0;
  logic                         n_rst;
  logic [ROB_W-1:0]             rob_head;
  logic                         cp_restore;
  logic [ROB_W-1:0]             cp_tail;
  logic [NUM_D_REG-1:0]         calc_list;
  logic [WAKE_W-1:0]            wake_valid;
  logic [WAKE_W-1:0][DR_W-1:0]  wake_addr;
  logic                         enq_valid;
  logic                         enq_ready;
  iq_req_t                      enq_entry;
  logic [ISSUE_W-1:0]           iss_valid;
  logic [ISSUE_W-1:0]           iss_ready;
  iq_req_t [ISSUE_W-1:0]        iss_entry;
  logic                         full;
  logic [$clog2(DEPTH):0]       count;

  issue_queue #(
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W),
    .WAKE_W  (WAKE_W)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rob_head   (rob_head),
    .cp_restore (cp_restore),
    .cp_tail    (cp_tail),
    .calc_list  (calc_list),
    .wake_valid (wake_valid),
    .wake_addr  (wake_addr),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .enq_entry  (enq_entry),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_entry  (iss_entry),
    .full       (full),
    .count      (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    iq_req_t req;
    bit      ra_rdy;
    bit      rt_rdy;
  } m_ent_t;

  m_ent_t  mq[$];
  bit      exp_valid [ISSUE_W];
  iq_req_t exp_entry [ISSUE_W];
  int      exp_idx   [ISSUE_W];

  function automatic int age_of(int rob, int head);
    return (rob - head + ROB_SIZE) % ROB_SIZE;
  endfunction

  function automatic bit hit(int a);
    bit h = calc_list[a];
    for (int j = 0; j < WAKE_W; j++) begin
      if (wake_valid[j] && (int'(wake_addr[j]) == a)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic bit is_flushed(m_ent_t e);
    if (!cp_restore) return 1'b0;
    return !(age_of(int'(e.req.rob_addr), int'(rob_head)) <
             age_of(int'(cp_tail), int'(rob_head)));
  endfunction

  function automatic bit is_eligible(m_ent_t e);
    bit a_ok = e.ra_rdy || !e.req.use_ra || hit(int'(e.req.ra_addr));
    bit t_ok = e.rt_rdy || !e.req.use_rt || hit(int'(e.req.rt_addr));
    return a_ok && t_ok && !is_flushed(e);
  endfunction

  // Bucket eligible entries by age (ages are unique) and hand them out in order.
  task automatic predict();
    int by_age [ROB_SIZE];
    int k = 0;
    for (int a = 0; a < ROB_SIZE; a++) by_age[a] = -1;
    foreach (mq[i]) begin
      if (is_eligible(mq[i])) by_age[age_of(int'(mq[i].req.rob_addr), int'(rob_head))] = i;
    end
    for (int p = 0; p < ISSUE_W; p++) begin
      exp_valid[p] = 1'b0;
      exp_entry[p] = '0;
      exp_idx[p]   = -1;
    end
    for (int a = 0; a < ROB_SIZE; a++) begin
      if (by_age[a] >= 0 && k < ISSUE_W) begin
        exp_valid[k] = 1'b1;
        exp_entry[k] = mq[by_age[a]].req;
        exp_idx[k]   = by_age[a];
        k++;
      end
    end
  endtask

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkLit(string name, logic [63:0] act, logic [63:0] exp);
    cmp(name, act, exp);
  endtask

  task automatic checkOutput();
    predict();
    cmp("count", 64'(count), 64'(mq.size()));
    cmp("full", 64'(full), 64'(mq.size() == DEPTH));
    cmp("enq_ready", 64'(enq_ready), 64'((mq.size() < DEPTH) && !cp_restore));
    for (int k = 0; k < ISSUE_W; k++) begin
      cmp($sformatf("iss_valid[%0d]", k), 64'(iss_valid[k]), 64'(exp_valid[k]));
      if (exp_valid[k]) begin
        cmp($sformatf("iss_entry[%0d]", k), 64'(iss_entry[k]), 64'(exp_entry[k]));
      end
    end
  endtask

  task automatic modelUpdate();
    m_ent_t nq[$];
    m_ent_t e;
    bit accept;
    predict();
    accept = enq_valid && (mq.size() < DEPTH) && !cp_restore;
    foreach (mq[i]) begin
      bit gone = is_flushed(mq[i]);
      for (int k = 0; k < ISSUE_W; k++) begin
        if (exp_valid[k] && iss_ready[k] && exp_idx[k] == i) gone = 1'b1;
      end
      if (!gone) begin
        e = mq[i];
        e.ra_rdy = e.ra_rdy || hit(int'(e.req.ra_addr));
        e.rt_rdy = e.rt_rdy || hit(int'(e.req.rt_addr));
        nq.push_back(e);
      end
    end
    if (accept) begin
      e.req    = enq_entry;
      e.ra_rdy = !enq_entry.use_ra || hit(int'(enq_entry.ra_addr));
      e.rt_rdy = !enq_entry.use_rt || hit(int'(enq_entry.rt_addr));
      nq.push_back(e);
    end
    mq = nq;
  endtask

  function automatic iq_req_t mk(int rob, bit ua, int ra, bit ut, int rt);
    iq_req_t r = '0;
    r.rob_addr  = ROB_W'(rob);
    r.alu_op    = ALU_OP_W'(rob + 1);
    r.immdt     = IMM_W'(rob * 37 + 5);
    r.use_ra    = ua;
    r.ra_addr   = DR_W'(ra);
    r.use_rt    = ut;
    r.rt_addr   = DR_W'(rt);
    r.write_dst = 1'b1;
    r.rw_addr   = DR_W'(rob + 8);
    r.rs_addr   = SR_W'(rob);
    return r;
  endfunction

  task automatic applyStimulus(bit ev, iq_req_t e, logic [ISSUE_W-1:0] rdy);
    enq_valid = ev;
    enq_entry = e;
    iss_ready = rdy;
  endtask

  task automatic settle();
    #2;
    checkOutput();
  endtask

  task automatic advance();
    modelUpdate();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_rst      = 1'b0;
    rob_head   = '0;
    cp_restore = 1'b0;
    cp_tail    = '0;
    calc_list  = '0;
    wake_valid = '0;
    wake_addr  = '0;
    applyStimulus(1'b0, '0, 2'b00);
    #1;
    checkLit("rst_count", 64'(count), 64'd0);
    checkLit("rst_full", 64'(full), 64'd0);
    checkLit("rst_enq_ready", 64'(enq_ready), 64'd1);
    checkLit("rst_iss_valid", 64'(iss_valid), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Fill to DEPTH, offer a 9th, then drain two per cycle in ROB order.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, mk(i, 0, 0, 0, 0), 2'b00);
      cycle();
    end
    applyStimulus(1'b1, mk(8, 0, 0, 0, 0), 2'b00);
    settle();
    checkLit("fill_full", 64'(full), 64'd1);
    checkLit("fill_enq_ready", 64'(enq_ready), 64'd0);
    checkLit("fill_count", 64'(count), 64'd8);
    advance();
    applyStimulus(1'b0, '0, 2'b11);
    settle();
    checkLit("drain_p0", 64'(iss_entry[0].rob_addr), 64'd0);
    checkLit("drain_p1", 64'(iss_entry[1].rob_addr), 64'd1);
    advance();
    for (int i = 0; i < 3; i++) cycle();
    settle();
    checkLit("drain_empty", 64'(count), 64'd0);
    advance();

    // Wakeup bypass from a broadcast, and enqueue with a same-cycle wake.
    applyStimulus(1'b1, mk(2, 1, 5, 0, 0), 2'b11);
    cycle();
    applyStimulus(1'b0, '0, 2'b11);
    settle();
    checkLit("wait_p5", 64'(iss_valid), 64'd0);
    advance();
    wake_valid   = 2'b01;
    wake_addr[0] = DR_W'(5);
    settle();
    checkLit("bypass_valid", 64'(iss_valid), 64'b01);
    checkLit("bypass_rob", 64'(iss_entry[0].rob_addr), 64'd2);
    advance();
    wake_valid = '0;
    applyStimulus(1'b1, mk(3, 0, 0, 1, 7), 2'b11);
    wake_valid   = 2'b10;
    wake_addr[1] = DR_W'(7);
    cycle();
    applyStimulus(1'b0, '0, 2'b11);
    wake_valid = '0;
    settle();
    checkLit("enq_wake_valid", 64'(iss_valid), 64'b01);
    checkLit("enq_wake_rob", 64'(iss_entry[0].rob_addr), 64'd3);
    advance();

    // Enqueue, issue and wake all in one cycle.
    applyStimulus(1'b1, mk(4, 1, 3, 0, 0), 2'b11);
    cycle();
    applyStimulus(1'b1, mk(5, 0, 0, 0, 0), 2'b11);
    wake_valid   = 2'b01;
    wake_addr[0] = DR_W'(3);
    settle();
    checkLit("combo_rob", 64'(iss_entry[0].rob_addr), 64'd4);
    advance();
    applyStimulus(1'b0, '0, 2'b11);
    wake_valid = '0;
    settle();
    checkLit("combo_next_rob", 64'(iss_entry[0].rob_addr), 64'd5);
    checkLit("combo_count", 64'(count), 64'd1);
    advance();

    // ROB wrap: head 14, entries 15,0,1.
    rob_head = ROB_W'(14);
    applyStimulus(1'b1, mk(15, 0, 0, 0, 0), 2'b00); cycle();
    applyStimulus(1'b1, mk(0, 0, 0, 0, 0), 2'b00);  cycle();
    applyStimulus(1'b1, mk(1, 0, 0, 0, 0), 2'b00);  cycle();
    applyStimulus(1'b0, '0, 2'b11);
    settle();
    checkLit("wrap_p0", 64'(iss_entry[0].rob_addr), 64'd15);
    checkLit("wrap_p1", 64'(iss_entry[1].rob_addr), 64'd0);
    advance();
    settle();
    checkLit("wrap_valid", 64'(iss_valid), 64'b01);
    checkLit("wrap_last", 64'(iss_entry[0].rob_addr), 64'd1);
    advance();

    // Restore: head 2, tail 5; 3,4 wait on p9 while 6,9 are ready but flushed.
    rob_head = ROB_W'(2);
    applyStimulus(1'b1, mk(3, 1, 9, 0, 0), 2'b00); cycle();
    applyStimulus(1'b1, mk(4, 1, 9, 0, 0), 2'b00); cycle();
    applyStimulus(1'b1, mk(6, 0, 0, 0, 0), 2'b00); cycle();
    applyStimulus(1'b1, mk(9, 0, 0, 0, 0), 2'b00); cycle();
    cp_restore = 1'b1;
    cp_tail    = ROB_W'(5);
    applyStimulus(1'b1, mk(7, 0, 0, 0, 0), 2'b11);
    settle();
    checkLit("restore_iss", 64'(iss_valid), 64'd0);
    checkLit("restore_enq_ready", 64'(enq_ready), 64'd0);
    advance();
    cp_restore = 1'b0;
    applyStimulus(1'b0, '0, 2'b00);
    settle();
    checkLit("restore_count", 64'(count), 64'd2);
    advance();
    calc_list[9] = 1'b1;
    applyStimulus(1'b0, '0, 2'b11);
    settle();
    checkLit("restore_p0", 64'(iss_entry[0].rob_addr), 64'd3);
    checkLit("restore_p1", 64'(iss_entry[1].rob_addr), 64'd4);
    advance();
    calc_list = '0;

    // Back-pressure on port 1.
    rob_head = ROB_W'(8);
    applyStimulus(1'b1, mk(10, 0, 0, 0, 0), 2'b00); cycle();
    applyStimulus(1'b1, mk(11, 0, 0, 0, 0), 2'b00); cycle();
    applyStimulus(1'b1, mk(12, 0, 0, 0, 0), 2'b00); cycle();
    applyStimulus(1'b0, '0, 2'b01);
    settle();
    checkLit("bp_p0_a", 64'(iss_entry[0].rob_addr), 64'd10);
    checkLit("bp_p1_a", 64'(iss_entry[1].rob_addr), 64'd11);
    advance();
    settle();
    checkLit("bp_p0_b", 64'(iss_entry[0].rob_addr), 64'd11);
    checkLit("bp_p1_b", 64'(iss_entry[1].rob_addr), 64'd12);
    advance();
    settle();
    checkLit("bp_valid_c", 64'(iss_valid), 64'b01);
    checkLit("bp_p0_c", 64'(iss_entry[0].rob_addr), 64'd12);
    advance();
    settle();
    checkLit("bp_empty", 64'(count), 64'd0);
    advance();

    // Asynchronous reset with five entries held.
    rob_head = '0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, mk(i, 0, 0, 0, 0), 2'b00);
      cycle();
    end
    applyStimulus(1'b0, '0, 2'b00);
    settle();
    checkLit("pre_rst_count", 64'(count), 64'd5);
    #1;
    n_rst = 1'b0;
    #1;
    checkLit("async_rst_count", 64'(count), 64'd0);
    checkLit("async_rst_iss", 64'(iss_valid), 64'd0);
    checkLit("async_rst_full", 64'(full), 64'd0);
    checkLit("async_rst_enq_ready", 64'(enq_ready), 64'd1);
    mq.delete();
    @(negedge clk);
    n_rst = 1'b1;
    applyStimulus(1'b0, '0, 2'b11);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
